// File: rtl/ssram_pipe_model.sv
// Behavioural pipelined SSRAM: byte-lane writes, READ_LATENCY-deep read pipe, tri-state DQ.
// Define SSRAM_BURST_EN to build the 4-beat wrapping burst logic driven by SSRAM_ADV_N.
module ssram_pipe_model #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 18,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  inout  wire  [DATA_WIDTH-1:0]   SSRAM_DQ,
  input  logic [ADDR_WIDTH-1:0]   SSRAM_ADDR,
  input  logic [DATA_WIDTH/8-1:0] SSRAM_BE_N,
  input  logic                    SSRAM_CE_N,
  input  logic                    SSRAM_WE_N,
  input  logic                    SSRAM_OE_N,
  input  logic                    SSRAM_ADV_N
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  logic                  op_rd;
  logic                  op_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [LANES-1:0]      lane_we;

  // Index 0 is the stage loaded at issue; index READ_LATENCY-1 feeds DQ.
  logic [READ_LATENCY-1:0] pipe_valid_reg;
  logic [DATA_WIDTH-1:0]   pipe_data_reg [READ_LATENCY];
  logic                    drive;

`ifdef SSRAM_BURST_EN
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] base_next;
  logic [1:0]            beat_reg;
  logic [1:0]            beat_next;
  logic                  burst_active_reg;
  logic                  burst_active_next;
  logic                  burst_wr_reg;
  logic                  burst_wr_next;
  logic [1:0]            wrap_lo;

  // An advance only counts while a burst is open; otherwise ADV_N=0 is a deselect.
  always_comb begin
    base_next         = base_reg;
    beat_next         = beat_reg;
    burst_active_next = burst_active_reg;
    burst_wr_next     = burst_wr_reg;
    op_rd             = 1'b0;
    op_wr             = 1'b0;
    acc_addr          = SSRAM_ADDR;
    wrap_lo           = base_reg[1:0] + beat_reg + 2'd1;
    if (!SSRAM_ADV_N && burst_active_reg) begin
      beat_next = beat_reg + 2'd1;
      acc_addr  = {base_reg[ADDR_WIDTH-1:2], wrap_lo};
      op_rd     = !burst_wr_reg;
      op_wr     = burst_wr_reg;
    end else if (!SSRAM_CE_N && SSRAM_ADV_N) begin
      base_next         = SSRAM_ADDR;
      beat_next         = 2'd0;
      burst_active_next = 1'b1;
      burst_wr_next     = !SSRAM_WE_N;
      op_rd             = SSRAM_WE_N;
      op_wr             = !SSRAM_WE_N;
    end else begin
      burst_active_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_reg         <= '0;
      beat_reg         <= 2'd0;
      burst_active_reg <= 1'b0;
      burst_wr_reg     <= 1'b0;
    end else begin
      base_reg         <= base_next;
      beat_reg         <= beat_next;
      burst_active_reg <= burst_active_next;
      burst_wr_reg     <= burst_wr_next;
    end
  end
`else
  logic unused_adv;
  assign unused_adv = SSRAM_ADV_N;

  always_comb begin
    op_rd    = !SSRAM_CE_N && SSRAM_WE_N;
    op_wr    = !SSRAM_CE_N && !SSRAM_WE_N;
    acc_addr = SSRAM_ADDR;
  end
`endif

  // A write is suppressed on a reset edge even if the bus shows one.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
      assign lane_we[gi] = rst_n && op_wr && !SSRAM_BE_N[gi];
    end
  endgenerate

  // Memory is never reset; the read word is captured at issue so later writes cannot alter it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_we[i]) begin
        mem[acc_addr][i*8 +: 8] <= SSRAM_DQ[i*8 +: 8];
      end
    end
    pipe_data_reg[0] <= mem[acc_addr];
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_data_reg[i] <= pipe_data_reg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= op_rd;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
      end
    end
  end

  assign drive    = pipe_valid_reg[READ_LATENCY-1] && !SSRAM_OE_N;
  assign SSRAM_DQ = drive ? pipe_data_reg[READ_LATENCY-1] : {DATA_WIDTH{1'bz}};

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && op_wr && drive) begin
      $display("SSRAM: bus contention");
    end
  end
`endif

endmodule

// File: tb/tb_ssram_pipe_model.sv
// Scoreboard bench for ssram_pipe_model: reads push expected words, checked when due on DQ.
// Burst scenarios are built only when SSRAM_BURST_EN is defined.
module tb_ssram_pipe_model;

  localparam int LAT = 2;
  localparam logic [31:0] REL = 32'hFFFF_FFFF;  // pulled-up value of a released bus

  typedef enum int {K_IDLE, K_RD, K_WR, K_ADV} kind_e;
  typedef struct {
    kind_e       kind;
    logic [17:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    bit          oe_n;
    bit          rst;
  } op_t;
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [17:0] addr;
  logic [3:0]  be_n;
  logic        ce_n;
  logic        we_n;
  logic        oe_n;
  logic        adv_n;
  logic        tb_drive;
  logic [31:0] tb_dq;
  tri1  [31:0] dq;

  assign dq = tb_drive ? tb_dq : 32'hzzzz_zzzz;

  ssram_pipe_model #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (18),
    .READ_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SSRAM_DQ   (dq),
    .SSRAM_ADDR (addr),
    .SSRAM_BE_N (be_n),
    .SSRAM_CE_N (ce_n),
    .SSRAM_WE_N (we_n),
    .SSRAM_OE_N (oe_n),
    .SSRAM_ADV_N(adv_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [31:0] ref_mem [int];
  logic [31:0] exp_v;
  logic [17:0] m_base;
  logic [1:0]  m_beat;
  bit          m_active;
  bit          m_wr;

  function automatic op_t mk(kind_e k, logic [17:0] a, logic [31:0] d, logic [3:0] be,
                             bit oe, bit rst);
    op_t o;
    o.kind = k; o.addr = a; o.data = d; o.be = be; o.oe_n = oe; o.rst = rst;
    return o;
  endfunction

  task automatic model_read(input logic [17:0] a);
    exp_t e;
    e.due  = cyc + LAT - 1;
    e.data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'hxxxx_xxxx;
    sb.push_back(e);
  endtask

  task automatic model_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'hxxxx_xxxx;
    for (int i = 0; i < 4; i++) begin
      if (!be[i]) w[i*8 +: 8] = d[i*8 +: 8];
    end
    ref_mem[int'(a)] = w;
  endtask

  // Drives one bus cycle, updates the reference model at the edge, returns at the next negedge.
  task automatic apply(input op_t op);
    logic [17:0] a;
    rst_n = !op.rst; oe_n = op.oe_n; addr = op.addr; be_n = op.be; tb_dq = op.data;
    ce_n = 1'b1; we_n = 1'b1; adv_n = 1'b1; tb_drive = 1'b0;
    case (op.kind)
      K_RD:    ce_n = 1'b0;
      K_WR:    begin ce_n = 1'b0; we_n = 1'b0; tb_drive = 1'b1; end
      K_ADV:   begin adv_n = 1'b0; tb_drive = m_active && m_wr; end
      default: ;
    endcase
    @(posedge clk);
    cyc++;
    if (op.rst) begin
      sb.delete(); m_active = 1'b0; m_wr = 1'b0; m_beat = 2'd0;
    end else begin
      case (op.kind)
        K_RD: begin
          m_active = 1'b1; m_wr = 1'b0; m_base = op.addr; m_beat = 2'd0;
          model_read(op.addr);
        end
        K_WR: begin
          m_active = 1'b1; m_wr = 1'b1; m_base = op.addr; m_beat = 2'd0;
          model_write(op.addr, op.data, op.be);
        end
        K_ADV: begin
`ifdef SSRAM_BURST_EN
          if (m_active) begin
            m_beat = m_beat + 2'd1;
            a = {m_base[17:2], m_base[1:0] + m_beat};
            if (m_wr) model_write(a, op.data, op.be);
            else model_read(a);
          end
`else
          m_active = 1'b0;
`endif
        end
        default: m_active = 1'b0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    op_t ops[$];
    ops.push_back(mk(K_WR, 18'h100, 32'h5A5A_0001, 4'h0, 0, 0));
    ops.push_back(mk(K_RD, 18'h100, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_WR, 18'h100, 32'h0BAD_0BAD, 4'h0, 0, 1));
    ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 1));
    repeat (4) ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_RD, 18'h100, 0, 4'hF, 0, 0));
    repeat (2) ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 0));
    foreach (ops[i]) begin
      apply(ops[i]);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_v = oe_n ? REL : sb[0].data;
        void'(sb.pop_front());
        n_checks++;
        $display("reset: cyc=%0d dq=%h want=%h", cyc, dq, exp_v);
        if (dq !== exp_v) begin
          n_errors++;
          $display("FAIL reset_read cyc=%0d dq=%h expected=%h", cyc, dq, exp_v);
        end
      end else if (!tb_drive) begin
        n_checks++;
        if (dq !== REL) begin
          n_errors++;
          $display("FAIL reset_released cyc=%0d dq=%h expected=released", cyc, dq);
        end
      end
    end
  endtask

  task automatic test_single();
    op_t ops[$];
    ops.push_back(mk(K_WR, 18'h00010, 32'hDEAD_BEEF, 4'h0, 0, 0));
    ops.push_back(mk(K_RD, 18'h00010, 0, 4'hF, 0, 0));
    repeat (3) ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 0));
    foreach (ops[i]) begin
      apply(ops[i]);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_v = oe_n ? REL : sb[0].data;
        void'(sb.pop_front());
        n_checks++;
        $display("single: cyc=%0d dq=%h want=%h", cyc, dq, exp_v);
        if (dq !== exp_v) begin
          n_errors++;
          $display("FAIL single_read cyc=%0d dq=%h expected=%h", cyc, dq, exp_v);
        end
      end else if (!tb_drive) begin
        n_checks++;
        if (dq !== REL) begin
          n_errors++;
          $display("FAIL single_released cyc=%0d dq=%h expected=released", cyc, dq);
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    op_t ops[$];
    ops.push_back(mk(K_WR, 18'h20, 32'h1122_3344, 4'b0000, 0, 0));
    ops.push_back(mk(K_WR, 18'h20, 32'hAABB_CCDD, 4'b1010, 0, 0));
    ops.push_back(mk(K_WR, 18'h21, 32'h0000_0000, 4'b0000, 0, 0));
    ops.push_back(mk(K_WR, 18'h21, 32'hFFFF_FFFF, 4'b0110, 0, 0));
    ops.push_back(mk(K_RD, 18'h20, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_RD, 18'h21, 0, 4'hF, 0, 0));
    repeat (2) ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 0));
    foreach (ops[i]) begin
      apply(ops[i]);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_v = oe_n ? REL : sb[0].data;
        void'(sb.pop_front());
        n_checks++;
        $display("lanes: cyc=%0d dq=%h want=%h", cyc, dq, exp_v);
        if (dq !== exp_v) begin
          n_errors++;
          $display("FAIL lanes_read cyc=%0d dq=%h expected=%h", cyc, dq, exp_v);
        end
      end else if (!tb_drive) begin
        n_checks++;
        if (dq !== REL) begin
          n_errors++;
          $display("FAIL lanes_released cyc=%0d dq=%h expected=released", cyc, dq);
        end
      end
    end
  endtask

`ifdef SSRAM_BURST_EN
  task automatic test_burst();
    op_t ops[$];
    ops.push_back(mk(K_WR,  18'h00006, 32'hA0A0_A0A0, 4'h0, 0, 0));
    ops.push_back(mk(K_ADV, 18'h3FFFF, 32'hA1A1_A1A1, 4'h0, 0, 0));
    ops.push_back(mk(K_ADV, 18'h3FFFF, 32'hA2A2_A2A2, 4'h0, 0, 0));
    ops.push_back(mk(K_ADV, 18'h3FFFF, 32'hA3A3_A3A3, 4'h0, 0, 0));
    ops.push_back(mk(K_RD,  18'h00005, 0, 4'hF, 0, 0));
    repeat (4) ops.push_back(mk(K_ADV, 18'h3FFFF, 0, 4'hF, 0, 0));
    repeat (3) ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 0));
    foreach (ops[i]) begin
      apply(ops[i]);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_v = oe_n ? REL : sb[0].data;
        void'(sb.pop_front());
        n_checks++;
        $display("burst: cyc=%0d dq=%h want=%h", cyc, dq, exp_v);
        if (dq !== exp_v) begin
          n_errors++;
          $display("FAIL burst_read cyc=%0d dq=%h expected=%h", cyc, dq, exp_v);
        end
      end else if (!tb_drive) begin
        n_checks++;
        if (dq !== REL) begin
          n_errors++;
          $display("FAIL burst_released cyc=%0d dq=%h expected=released", cyc, dq);
        end
      end
    end
  endtask
`endif

  task automatic test_streaming();
    op_t ops[$];
    for (int k = 0; k < 4; k++) begin
      ops.push_back(mk(K_WR, 18'h30 + 18'(k), 32'hC0DE_0030 + 32'(k * 32'h0101_0000), 4'h0, 0, 0));
    end
    ops.push_back(mk(K_RD, 18'h30, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_RD, 18'h31, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_RD, 18'h32, 0, 4'hF, 1, 0));
    ops.push_back(mk(K_RD, 18'h33, 0, 4'hF, 0, 0));
    repeat (3) ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 0));
    foreach (ops[i]) begin
      apply(ops[i]);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_v = oe_n ? REL : sb[0].data;
        void'(sb.pop_front());
        n_checks++;
        $display("stream: cyc=%0d oe_n=%0b dq=%h want=%h", cyc, oe_n, dq, exp_v);
        if (dq !== exp_v) begin
          n_errors++;
          $display("FAIL stream_read cyc=%0d dq=%h expected=%h", cyc, dq, exp_v);
        end
      end else if (!tb_drive) begin
        n_checks++;
        if (dq !== REL) begin
          n_errors++;
          $display("FAIL stream_released cyc=%0d dq=%h expected=released", cyc, dq);
        end
      end
    end
  endtask

  task automatic test_reset_burst();
    op_t ops[$];
    for (int k = 0; k < 4; k++) begin
      ops.push_back(mk(K_WR, 18'h40 + 18'(k), 32'h1111_0040 + 32'(k), 4'h0, 0, 0));
    end
    ops.push_back(mk(K_RD,  18'h40, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_ADV, 18'h3FFFF, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_ADV, 18'h3FFFF, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 1));
    ops.push_back(mk(K_ADV, 18'h3FFFF, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 0));
    ops.push_back(mk(K_RD,  18'h41, 0, 4'hF, 0, 0));
    repeat (2) ops.push_back(mk(K_IDLE, 0, 0, 4'hF, 0, 0));
    foreach (ops[i]) begin
      apply(ops[i]);
      if (sb.size() != 0 && sb[0].due == cyc) begin
        exp_v = oe_n ? REL : sb[0].data;
        void'(sb.pop_front());
        n_checks++;
        $display("rst_burst: cyc=%0d dq=%h want=%h", cyc, dq, exp_v);
        if (dq !== exp_v) begin
          n_errors++;
          $display("FAIL rst_burst_read cyc=%0d dq=%h expected=%h", cyc, dq, exp_v);
        end
      end else if (!tb_drive) begin
        n_checks++;
        if (dq !== REL) begin
          n_errors++;
          $display("FAIL rst_burst_released cyc=%0d dq=%h expected=released", cyc, dq);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b0; adv_n = 1'b1;
    addr = '0; be_n = 4'hF; tb_drive = 1'b0; tb_dq = '0;
    m_base = '0; m_beat = 2'd0; m_active = 1'b0; m_wr = 1'b0;
    repeat (2) apply(mk(K_IDLE, 0, 0, 4'hF, 0, 1));
    test_reset();
    test_single();
    test_byte_lanes();
`ifdef SSRAM_BURST_EN
    test_burst();
`endif
    test_streaming();
    test_reset_burst();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
